// File: rtl/io_output_capture_pkg.sv
// Shared sizing and entry-field layout for the output capture block.
// OUT_TIMESTAMP_EN widens each entry with a cycle stamp above the overflow bit.
package io_output_capture_pkg;

   localparam int IO_WIDTH      = 16;
   localparam int IO_DEPTH_LOG2 = 2;
   localparam int IO_DROP_W     = 8;

   // Entry layout, LSB first: data, overflow flag, optional stamp.
   localparam int ENTRY_DATA_LSB = 0;

   function automatic int entry_ovf_bit(input int width);
      return width;
   endfunction

   function automatic int entry_stamp_lsb(input int width);
      return width + 1;
   endfunction

   function automatic int entry_width(input int width, input bit with_stamp);
      return with_stamp ? (2 * width + 1) : (width + 1);
   endfunction

endpackage

// File: rtl/io_capture_fifo.sv
// Generic synchronous FIFO with combinational head read and occupancy counter.
// Full/empty come from the counter, so pointers are free to wrap naturally.
module io_capture_fifo #(
   parameter int EW = 17,
   parameter int AW = 2
) (
   input  logic          clk,
   input  logic          srst,
   input  logic          push,
   input  logic          pop,
   input  logic [EW-1:0] din,
   output logic [EW-1:0] dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   localparam int DEPTH = 1 << AW;

   logic [AW-1:0]  wr_ptr_reg;
   logic [AW-1:0]  rd_ptr_reg;
   logic [AW:0]    count_reg;
   logic [EW-1:0]  mem_reg [DEPTH];
   logic [DEPTH-1:0] wen;
   logic           do_push;
   logic           do_pop;

   assign empty = (count_reg == '0);
   assign full  = (count_reg == (AW+1)'(DEPTH));
   assign count = count_reg;

   // A pop in the same cycle frees the slot the push needs, even when full.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wen
         assign wen[gi] = do_push && (wr_ptr_reg == AW'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (srst) begin
            mem_reg[i] <= '0;
         end else if (wen[i]) begin
            mem_reg[i] <= din;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Stale slots are never exposed: an empty FIFO presents zero.
   assign dout = empty ? '0 : mem_reg[rd_ptr_reg];

endmodule

// File: rtl/io_output_capture.sv
// Captures one word per rising edge of the processor Output strobe into a FIFO
// drained by valid/ready; counts drops. OUT_TIMESTAMP_EN adds a per-entry cycle stamp.
module io_output_capture
   import io_output_capture_pkg::*;
#(
   parameter int WIDTH      = IO_WIDTH,
   parameter int DEPTH_LOG2 = IO_DEPTH_LOG2,
   parameter int DROP_W     = IO_DROP_W
) (
   input  logic                  CLK,
   input  logic                  Reset,
   input  logic                  Output,
   input  logic [WIDTH-1:0]      Outputio,
   input  logic                  Overflow,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_ovf,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DEPTH_LOG2:0]   fifo_count,
   output logic [DROP_W-1:0]     drop_count
`ifdef OUT_TIMESTAMP_EN
   ,
   output logic [WIDTH-1:0]      out_stamp
`endif
);

`ifdef OUT_TIMESTAMP_EN
   localparam bit STAMP_EN = 1'b1;
`else
   localparam bit STAMP_EN = 1'b0;
`endif
   localparam int EW      = entry_width(WIDTH, STAMP_EN);
   localparam int OVF_BIT = entry_ovf_bit(WIDTH);

   logic              strobe_q_reg;
   logic              capture;
   logic              pop_fire;
   logic              drop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [EW-1:0]     entry_in;
   logic [EW-1:0]     entry_out;
   logic [DROP_W-1:0] drop_count_reg;

   // Level strobe may stay high for many cycles; only its rising edge captures.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         strobe_q_reg <= 1'b0;
      end else begin
         strobe_q_reg <= Output;
      end
   end

   assign capture  = Output & ~strobe_q_reg;
   assign pop_fire = out_valid & out_ready;
   assign drop     = capture & fifo_full & ~pop_fire;

   always_ff @(posedge CLK) begin
      if (Reset) begin
         drop_count_reg <= '0;
      end else if (drop && (drop_count_reg != {DROP_W{1'b1}})) begin
         drop_count_reg <= drop_count_reg + DROP_W'(1);
      end
   end

`ifdef OUT_TIMESTAMP_EN
   logic [WIDTH-1:0] stamp_reg;

   always_ff @(posedge CLK) begin
      if (Reset) begin
         stamp_reg <= '0;
      end else begin
         stamp_reg <= stamp_reg + WIDTH'(1);
      end
   end

   assign entry_in  = {stamp_reg, Overflow, Outputio};
   assign out_stamp = entry_out[entry_stamp_lsb(WIDTH) +: WIDTH];
`else
   assign entry_in  = {Overflow, Outputio};
`endif

   io_capture_fifo #(
      .EW (EW),
      .AW (DEPTH_LOG2)
   ) u_fifo (
      .clk   (CLK),
      .srst  (Reset),
      .push  (capture),
      .pop   (pop_fire),
      .din   (entry_in),
      .dout  (entry_out),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign out_valid  = ~fifo_empty;
   assign out_data   = entry_out[ENTRY_DATA_LSB +: WIDTH];
   assign out_ovf    = entry_out[OVF_BIT];
   assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_io_output_capture.sv
// Self-checking bench for io_output_capture: directed table, hand corner sequences,
// and randomized traffic against a queue-based model. Define OUT_TIMESTAMP_EN for stamp checks.
module tb_io_output_capture;
   import io_output_capture_pkg::*;

   logic                   CLK = 1'b0;
   logic                   Reset = 1'b1;
   logic                   Output = 1'b0;
   logic [IO_WIDTH-1:0]    Outputio = '0;
   logic                   Overflow = 1'b0;
   logic [IO_WIDTH-1:0]    out_data;
   logic                   out_ovf;
   logic                   out_valid;
   logic                   out_ready = 1'b0;
   logic [IO_DEPTH_LOG2:0] fifo_count;
   logic [IO_DROP_W-1:0]   drop_count;
`ifdef OUT_TIMESTAMP_EN
   logic [IO_WIDTH-1:0]    out_stamp;
`endif

   io_output_capture dut (
      .CLK        (CLK),
      .Reset      (Reset),
      .Output     (Output),
      .Outputio   (Outputio),
      .Overflow   (Overflow),
      .out_data   (out_data),
      .out_ovf    (out_ovf),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .fifo_count (fifo_count),
      .drop_count (drop_count)
`ifdef OUT_TIMESTAMP_EN
      ,
      .out_stamp  (out_stamp)
`endif
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;

   // Reference model: a plain queue of captured words plus a drop tally.
   typedef struct packed {
      logic        ovf;
      logic [15:0] data;
      logic [15:0] stamp;
   } ment_t;

   ment_t       mq[$];
   int          m_drop = 0;
   logic        m_prev = 1'b0;
   logic [15:0] m_time = '0;
   localparam int M_DEPTH = 1 << IO_DEPTH_LOG2;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance the model with the inputs about to be sampled, then clock the DUT.
   task automatic cycle();
      ment_t e;
      if (!Reset && out_valid && out_ready)
         $display("[TB] t=%0t pop data=%h ovf=%b", $time, out_data, out_ovf);
      if (Reset) begin
         mq.delete();
         m_drop = 0;
         m_prev = 1'b0;
         m_time = '0;
      end else begin
         if (out_ready && mq.size() > 0) void'(mq.pop_front());
         if (Output && !m_prev) begin
            e.ovf = Overflow; e.data = Outputio; e.stamp = m_time;
            if (mq.size() < M_DEPTH) mq.push_back(e);
            else if (m_drop < 255) m_drop++;
         end
         m_prev = Output;
         m_time = m_time + 16'd1;
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic strobe(input logic [15:0] v);
      Outputio = v; Output = 1'b1;
      cycle();
      Output = 1'b0;
      cycle();
   endtask

   task automatic chk_model();
      chk("rnd_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("rnd_count", 32'(fifo_count), 32'(mq.size()));
      chk("rnd_drop", 32'(drop_count), 32'(m_drop));
      chk("rnd_data", 32'(out_data), (mq.size() != 0) ? 32'(mq[0].data) : 32'd0);
      chk("rnd_ovf", 32'(out_ovf), (mq.size() != 0) ? 32'(mq[0].ovf) : 32'd0);
`ifdef OUT_TIMESTAMP_EN
      chk("rnd_stamp", 32'(out_stamp), (mq.size() != 0) ? 32'(mq[0].stamp) : 32'd0);
`endif
   endtask

   typedef struct packed {
      logic        o;
      logic [15:0] io;
      logic        ovf;
      logic        rdy;
      logic [2:0]  cnt;
      logic        vld;
      logic [15:0] data;
      logic        eovf;
   } vec_t;

   vec_t        tab [10];
   logic [15:0] exp4 [4];

   initial begin
      // single write held 3 cycles, pop, idle ready on empty; then overflow tagging
      tab[0] = '{1'b1, 16'h0037, 1'b0, 1'b0, 3'd1, 1'b1, 16'h0037, 1'b0};
      tab[1] = '{1'b1, 16'h0037, 1'b0, 1'b0, 3'd1, 1'b1, 16'h0037, 1'b0};
      tab[2] = '{1'b1, 16'h0037, 1'b0, 1'b0, 3'd1, 1'b1, 16'h0037, 1'b0};
      tab[3] = '{1'b0, 16'h0037, 1'b0, 1'b1, 3'd0, 1'b0, 16'h0000, 1'b0};
      tab[4] = '{1'b0, 16'h0000, 1'b0, 1'b1, 3'd0, 1'b0, 16'h0000, 1'b0};
      tab[5] = '{1'b1, 16'h8000, 1'b1, 1'b0, 3'd1, 1'b1, 16'h8000, 1'b1};
      tab[6] = '{1'b0, 16'h0001, 1'b0, 1'b0, 3'd1, 1'b1, 16'h8000, 1'b1};
      tab[7] = '{1'b1, 16'h0001, 1'b0, 1'b0, 3'd2, 1'b1, 16'h8000, 1'b1};
      tab[8] = '{1'b0, 16'h0001, 1'b0, 1'b1, 3'd1, 1'b1, 16'h0001, 1'b0};
      tab[9] = '{1'b0, 16'h0001, 1'b0, 1'b1, 3'd0, 1'b0, 16'h0000, 1'b0};

      // Reset held two cycles
      Reset = 1'b1;
      cycle(); cycle();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_drop", 32'(drop_count), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      Reset = 1'b0;
      cycle();

      for (int i = 0; i < 10; i++) begin
         Output = tab[i].o; Outputio = tab[i].io; Overflow = tab[i].ovf; out_ready = tab[i].rdy;
         cycle();
         $display("[TB] vec %0d out_valid=%b count=%0d data=%h ovf=%b", i, out_valid, fifo_count, out_data, out_ovf);
         chk($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(tab[i].cnt));
         chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tab[i].vld));
         chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(tab[i].data));
         chk($sformatf("vec%0d_ovf", i), 32'(out_ovf), 32'(tab[i].eovf));
         chk($sformatf("vec%0d_drop", i), 32'(drop_count), 32'd0);
      end
      Output = 1'b0; out_ready = 1'b0; Overflow = 1'b0;
      cycle();

      // Fill past capacity, then drain in order
      for (int v = 1; v <= 6; v++) strobe(16'(v));
      chk("fill_count", 32'(fifo_count), 32'd4);
      chk("fill_drop", 32'(drop_count), 32'd2);
      out_ready = 1'b1;
      for (int v = 1; v <= 4; v++) begin
         chk($sformatf("drain%0d", v), 32'(out_data), 32'(v));
         cycle();
      end
      out_ready = 1'b0;
      chk("drain_empty", 32'(out_valid), 32'd0);

      // Capture while full with a same-cycle pop
      for (int v = 0; v < 4; v++) strobe(16'(16'h10 + v));
      Outputio = 16'hBEEF; Output = 1'b1; out_ready = 1'b1;
      cycle();
      Output = 1'b0;
      chk("pp_count", 32'(fifo_count), 32'd4);
      chk("pp_drop", 32'(drop_count), 32'd2);
      exp4[0] = 16'h0011; exp4[1] = 16'h0012; exp4[2] = 16'h0013; exp4[3] = 16'hBEEF;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("pp_drain%0d", i), 32'(out_data), 32'(exp4[i]));
         cycle();
      end
      out_ready = 1'b0;
      chk("pp_empty", 32'(fifo_count), 32'd0);

      // Drop counter saturation
      for (int v = 0; v < 4; v++) strobe(16'(v));
      for (int v = 0; v < 300; v++) strobe(16'hAAAA);
      chk("sat_drop", 32'(drop_count), 32'd255);
      chk("sat_count", 32'(fifo_count), 32'd4);

      // Reset mid-run with 3 entries queued; Output high across reset release
      out_ready = 1'b1; cycle(); out_ready = 1'b0;
      chk("mid_count3", 32'(fifo_count), 32'd3);
      Outputio = 16'h5A5A; Output = 1'b1; Reset = 1'b1;
      cycle();
      chk("mid_valid", 32'(out_valid), 32'd0);
      chk("mid_count", 32'(fifo_count), 32'd0);
      chk("mid_drop", 32'(drop_count), 32'd0);
      Reset = 1'b0;
      cycle(); cycle();
      chk("rel_count", 32'(fifo_count), 32'd1);
      chk("rel_data", 32'(out_data), 32'h5A5A);
      Output = 1'b0;

`ifdef OUT_TIMESTAMP_EN
      Reset = 1'b1; cycle(); Reset = 1'b0;
      for (int i = 0; i < 5; i++) cycle();
      Outputio = 16'h0777; Output = 1'b1;
      cycle();
      Output = 1'b0;
      chk("stamp5", 32'(out_stamp), 32'd5);
`endif

      // Randomized traffic against the model
      Reset = 1'b1; cycle(); Reset = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         Reset     = ($urandom_range(0, 299) == 0);
         Output    = ($urandom_range(0, 2) == 0);
         Outputio  = 16'($urandom);
         Overflow  = 1'($urandom);
         out_ready = ($urandom_range(0, 3) == 0);
         cycle();
         chk_model();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
